// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared types and constants for the memory-stage controller.
//   mem_op_t    : request opcode as carried in the EX/MEM pipeline register
//   mem_state_t : controller FSM state
//   WORD_W      : data memory word width
//   decode_op() : maps the raw 3-bit opcode field onto mem_op_t, folding the
//                 unused encodings 5..7 onto NOP
// -----------------------------------------------------------------------------
package mem_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_LOAD  = 3'd1,
        OP_STORE = 3'd2,
        OP_PUSH  = 3'd3,
        OP_POP   = 3'd4
    } mem_op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } mem_state_t;

    function automatic mem_op_t decode_op(input logic [2:0] raw);
        case (raw)
            3'd1:    return OP_LOAD;
            3'd2:    return OP_STORE;
            3'd3:    return OP_PUSH;
            3'd4:    return OP_POP;
            default: return OP_NOP;
        endcase
    endfunction

endpackage

// File: rtl/sp_unit.sv
// -----------------------------------------------------------------------------
// sp_unit
// Stack pointer register for the memory stage. Resets to the top of memory
// (all ones), post-decrements on PUSH and pre-increments on POP.
//
// Optional feature: MEM_STACK_CHECK_EN. When defined, a PUSH at sp=0 or a POP
// at sp=2^N-1 is refused (push_ok/pop_ok stay low, sp holds) and the sticky
// stack_fault flag is raised until reset. When undefined, sp wraps silently.
//
// Ports:
//   clk         in   clock
//   rst         in   synchronous active-low reset
//   push_req    in   PUSH accepted this cycle
//   pop_req     in   POP accepted this cycle
//   sp          out  current stack pointer
//   sp_inc      out  sp+1 (modulo 2^N), the address a POP reads
//   push_ok     out  PUSH allowed to touch memory and sp
//   pop_ok      out  POP allowed to touch memory and sp
//   stack_fault out  sticky overflow/underflow flag (MEM_STACK_CHECK_EN only)
// -----------------------------------------------------------------------------
module sp_unit #(
    parameter int N = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_req,
    input  logic         pop_req,
    output logic [N-1:0] sp,
    output logic [N-1:0] sp_inc,
    output logic         push_ok,
    output logic         pop_ok
`ifdef MEM_STACK_CHECK_EN
    ,
    output logic         stack_fault
`endif
);

    // Natural N-bit overflow gives the modulo-2^N wrap.
    assign sp_inc = sp + N'(1);

`ifdef MEM_STACK_CHECK_EN
    assign push_ok = push_req && (sp != '0);
    assign pop_ok  = pop_req  && (sp != '1);
`else
    assign push_ok = push_req;
    assign pop_ok  = pop_req;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sp <= '1;
        end else if (push_ok) begin
            sp <= sp - N'(1);
        end else if (pop_ok) begin
            sp <= sp_inc;
        end
    end

`ifdef MEM_STACK_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            stack_fault <= 1'b0;
        end else if ((push_req && !push_ok) || (pop_req && !pop_ok)) begin
            stack_fault <= 1'b1;
        end
    end
`endif

endmodule

// File: rtl/mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl
// Memory-stage controller between the EX/MEM register and the data memory.
// Accepts one LOAD/STORE/PUSH/POP per transaction, drives the memory ports,
// owns the stack pointer (sp_unit) and stalls upstream while a read is in
// flight. Load results reach write-back with a one-cycle wb_valid pulse.
//
// Optional feature: MEM_STACK_CHECK_EN adds the stack_fault port and refuses
// stack overflow/underflow (see sp_unit).
//
// Parameters:
//   N       address width (2^N words of WORD_W bits)
//   RD_LAT  cycles from mem_re to the cycle mem_rdata is sampled, 1..7
//
// Ports:
//   clk, rst              clock, synchronous active-low reset
//   in_valid/in_op/in_addr/in_wdata/in_rd   request from EX/MEM
//   in_ready              request accepted this cycle (decoded from state)
//   mem_re/mem_we         data memory read/write enables (registered)
//   mem_raddr/mem_waddr   data memory addresses (registered)
//   mem_wdata             data memory write data (registered)
//   mem_rdata             data memory read data
//   wb_valid/wb_rd/wb_data  load result to write-back (registered)
//   sp                    current stack pointer
//   stack_fault           sticky stack fault (MEM_STACK_CHECK_EN only)
// -----------------------------------------------------------------------------
module mem_stage_ctrl
    import mem_pkg::*;
#(
    parameter int N      = 10,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [2:0]        in_op,
    input  logic [N-1:0]      in_addr,
    input  logic [WORD_W-1:0] in_wdata,
    input  logic [2:0]        in_rd,
    output logic              in_ready,
    output logic              mem_re,
    output logic              mem_we,
    output logic [N-1:0]      mem_raddr,
    output logic [N-1:0]      mem_waddr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic [2:0]        wb_rd,
    output logic [WORD_W-1:0] wb_data,
    output logic [N-1:0]      sp
`ifdef MEM_STACK_CHECK_EN
    ,
    output logic              stack_fault
`endif
);

    localparam logic [2:0] LAT_INIT = 3'(RD_LAT - 1);

    mem_state_t   state;
    logic [2:0]   lat_cnt;
    logic [2:0]   pend_rd;
    mem_op_t      op;
    logic         accept;
    logic         push_ok;
    logic         pop_ok;
    logic [N-1:0] sp_inc;

    assign in_ready = (state == S_IDLE);
    assign accept   = in_ready && in_valid;
    assign op       = decode_op(in_op);

    sp_unit #(.N(N)) u_sp (
        .clk         (clk),
        .rst         (rst),
        .push_req    (accept && (op == OP_PUSH)),
        .pop_req     (accept && (op == OP_POP)),
        .sp          (sp),
        .sp_inc      (sp_inc),
        .push_ok     (push_ok),
        .pop_ok      (pop_ok)
`ifdef MEM_STACK_CHECK_EN
        ,
        .stack_fault (stack_fault)
`endif
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            lat_cnt   <= '0;
            pend_rd   <= '0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_raddr <= '0;
            mem_waddr <= '0;
            mem_wdata <= '0;
            wb_valid  <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
        end else begin
            // Enables and the write-back strobe are single-cycle pulses.
            mem_re   <= 1'b0;
            mem_we   <= 1'b0;
            wb_valid <= 1'b0;

            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        unique case (op)
                            OP_STORE: begin
                                mem_we    <= 1'b1;
                                mem_waddr <= in_addr;
                                mem_wdata <= in_wdata;
                            end
                            OP_PUSH: begin
                                // Post-decrement: write lands at the current sp.
                                if (push_ok) begin
                                    mem_we    <= 1'b1;
                                    mem_waddr <= sp;
                                    mem_wdata <= in_wdata;
                                end
                            end
                            OP_LOAD: begin
                                mem_re    <= 1'b1;
                                mem_raddr <= in_addr;
                                pend_rd   <= in_rd;
                                state     <= S_ISSUE;
                            end
                            OP_POP: begin
                                // Pre-increment: read from the new sp.
                                if (pop_ok) begin
                                    mem_re    <= 1'b1;
                                    mem_raddr <= sp_inc;
                                    pend_rd   <= in_rd;
                                    state     <= S_ISSUE;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_ISSUE: begin
                    lat_cnt <= LAT_INIT;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (lat_cnt == 3'd0) begin
                        wb_valid <= 1'b1;
                        wb_rd    <= pend_rd;
                        wb_data  <= mem_rdata;
                        state    <= S_IDLE;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage controller sitting directly upstream of the data memory in the pipelined processor. Accepts one load/store/push/pop request per transaction from the EX/MEM pipeline register. Drives the data memory's read/write enables, addresses and write data, and owns the stack pointer. Waits out the memory's read latency, stalling upstream while a read is in flight, and delivers load results to write-back with a single-cycle valid pulse.

## Interface
Parameters:
- `N`, 10: memory address width; depth is 2^N words of 16 bits.
- `RD_LAT`, 2: cycles from `mem_re` assertion to the cycle `mem_rdata` is sampled; legal range 1..7.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  request present.
- `in_op`  in  3  opcode: NOP=0, LOAD=1, STORE=2, PUSH=3, POP=4; 5..7 are treated as NOP.
- `in_addr`  in  N  address for LOAD/STORE; ignored for PUSH/POP.
- `in_wdata`  in  16  data for STORE/PUSH.
- `in_rd`  in  3  destination register for LOAD/POP.
- `in_ready`  out  1  high = request accepted this cycle; low = upstream must hold.
- `mem_re`, `mem_we`  out  1  memory read and write enables.
- `mem_raddr`, `mem_waddr`  out  N  memory read and write addresses.
- `mem_wdata`  out  16  memory write data.
- `mem_rdata`  in  16  memory read data.
- `wb_valid`  out  1  one-cycle pulse; load result is valid.
- `wb_rd`  out  3  destination register of the result.
- `wb_data`  out  16  result data.
- `sp`  out  N  current stack pointer.
- `stack_fault`  out  1  sticky fault flag; present only with `MEM_STACK_CHECK_EN`.

## Operation
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: `in_ready`=1. On accept (`in_valid`=1):
    - STORE/PUSH: stay in IDLE.
    - LOAD/POP: go to ISSUE.
    - NOP: no action.
  - ISSUE: `mem_re`=1 for exactly this cycle. Latency counter loads `RD_LAT`-1. Go to WAIT.
  - WAIT: counter decrements each cycle. When counter=0, sample `mem_rdata` into `wb_data`, pulse `wb_valid` the next cycle, and return to IDLE.
- STORE: registered `mem_we`=1, `mem_waddr`=`in_addr`, `mem_wdata`=`in_wdata`, all for the one cycle after accept.
- PUSH: same as STORE, but the write address is `sp`. `sp` then decrements by 1 (post-decrement).
- POP: `sp` increments by 1 on accept (pre-increment). `mem_raddr` = new `sp`.
- Arithmetic on `sp` is modulo 2^N; without the check macro, wrap-around is silent.
- `in_ready`=0 throughout ISSUE and WAIT, so no request is accepted while a read is outstanding.
- Write-after-read ordering is preserved because issue is strictly in order.
- Reset values (when `rst`=0 at a clock edge):
  - state=IDLE, `sp`=2^N-1.
  - `mem_re`=`mem_we`=0, `mem_raddr`=`mem_waddr`=0, `mem_wdata`=0.
  - `wb_valid`=0, `wb_rd`=0, `wb_data`=0.
  - `stack_fault`=0.
- Reset mid-read aborts the read: no `wb_valid` is produced and returned data is discarded.

## Timing
- Store/push: accept at edge A; `mem_we` high during cycle A+1 only.
- Load/pop: accept at edge A; `mem_re` high during cycle A+1; `wb_valid` high during cycle A+2+`RD_LAT`.
- `in_ready` is low from cycle A+1 through cycle A+1+`RD_LAT`, and high again in the `wb_valid` cycle.
- Back-to-back stores: one per cycle, no bubbles.
- All outputs are registered except `in_ready`, which is decoded from state.

## Configuration
- `MEM_STACK_CHECK_EN` defined:
  - A PUSH when `sp`=0, or a POP when `sp`=2^N-1, is suppressed: no memory access, `sp` unchanged.
  - The suppressed request is still consumed (accepted).
  - `stack_fault` is set and held until reset.
- Not defined: the `stack_fault` port is absent and `sp` wraps modulo 2^N.

## Structure
- Shared package `mem_pkg`: opcode enum `mem_op_t` (NOP/LOAD/STORE/PUSH/POP), FSM state enum `mem_state_t`, constant `WORD_W`=16.
- One sub-module, `sp_unit`: the stack pointer register with inc/dec, wrap handling and the fault check.

## Test plan
- Reset: `rst`=0 for 2 cycles -> `sp`=1023, all enables 0, `in_ready`=1.
- STORE addr 5 data 0xBEEF, then LOAD addr 5, rd 3 -> `mem_we` 1 cycle with addr 5; `mem_re` 1 cycle; `wb_valid` at A+4 with `wb_rd`=3, `wb_data`=0xBEEF; `in_ready` low for 3 cycles.
- PUSH 0x1111, PUSH 0x2222, POP, POP -> writes to 1023 then 1022, `sp`=1021; pops return 0x2222 then 0x1111, `sp`=1023.
- Four consecutive STOREs to addrs 0..3 -> `in_ready` stays 1 and `mem_we` is high for 4 consecutive cycles.
- POP at `sp`=1023 with `MEM_STACK_CHECK_EN` -> no `mem_re`, `stack_fault`=1, `sp`=1023; without the macro -> `sp`=0, read issued at addr 0.
- Reset asserted during WAIT of a LOAD -> no `wb_valid`, state IDLE, `in_ready`=1 after reset releases.
